// File: rtl/bin2bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_pkg
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_t     : FSM encoding (IDLE / SHIFT / DONE)
//   ADJ_THRESH  : digit value at or above which the +3 adjust is applied
//   ADJ_ADD     : adjust amount
//   *_DEF       : default widths (8-bit product, 3 BCD digits)
// ---------------------------------------------------------------------------
package bin2bcd_pkg;

    localparam int BIN_W_DEF = 8;
    localparam int DIG_DEF   = 3;
    localparam int CNT_W_DEF = 4;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_if
// Request/result bundle between the multiplier controller and the converter.
//   start   : conversion request (master -> slave)
//   bin_in  : binary value, sampled with start (master -> slave)
//   busy    : converter not idle (slave -> master)
//   done    : one-cycle completion pulse (slave -> master)
//   bcd_out : packed BCD result, ones digit in [3:0] (slave -> master)
//   blank   : leading-zero blank mask, only when BCD_LZB_EN is defined
// ---------------------------------------------------------------------------
interface bin2bcd_seq_if #(
    parameter int BIN_W = 8,
    parameter int DIG   = 3
);
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic [4*DIG-1:0] bcd_out;
`ifdef BCD_LZB_EN
    logic [DIG-1:0]   blank;

    modport master (output start, bin_in, input busy, done, bcd_out, blank);
    modport slave  (input start, bin_in, output busy, done, bcd_out, blank);
`else
    modport master (output start, bin_in, input busy, done, bcd_out);
    modport slave  (input start, bin_in, output busy, done, bcd_out);
`endif
endinterface

// File: rtl/bin2bcd_seq_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble digit correction: digits >= 5 get +3 (mod 16)
// so that the following left shift carries correctly into the next digit.
//   i_digit : 4-bit BCD digit before adjust
//   o_digit : 4-bit digit after adjust
// ---------------------------------------------------------------------------
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);
    assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit + ADJ_ADD) : i_digit;
endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift-add-3 converter, one iteration per clock. Converts the
// multiplier product into packed BCD for the display stage.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low; aborts any conversion in progress
//   bus   : bin2bcd_seq_if.slave (start, bin_in, busy, done, bcd_out[, blank])
// Optional feature macro: BCD_LZB_EN adds the registered leading-zero
// blank mask (blank[0] is never set so a zero value shows one "0").
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; loads bin_in into the scratch register
// SHIFT | BIN_W iterations of adjust-then-shift; result latched on last
// DONE  | one-cycle done pulse, start ignored, then back to IDLE
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEF,
    parameter int DIG   = DIG_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    bin2bcd_seq_if.slave bus
);
    localparam int SCR_W = 4*DIG + BIN_W;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [SCR_W-1:0] r_scratch;
    logic [SCR_W-1:0] w_adj;
    logic [SCR_W-1:0] w_shifted;
    logic [4*DIG-1:0] w_adj_dig;
    logic [4*DIG-1:0] w_new_bcd;
    logic [4*DIG-1:0] r_bcd;
    logic             w_load;
    logic             w_step;
    logic             w_last;

    // Upper field holds the BCD digits; adjust them all in parallel.
    for (genvar g = 0; g < DIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[BIN_W + 4*g +: 4]),
            .o_digit (w_adj_dig[4*g +: 4])
        );
    end

    assign w_adj     = {w_adj_dig, r_scratch[BIN_W-1:0]};
    assign w_shifted = w_adj << 1;
    assign w_new_bcd = w_shifted[SCR_W-1:BIN_W];
    assign w_last    = (r_cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_step      = 1'b1;
                w_state_nxt = w_last ? DONE : SHIFT;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef BCD_LZB_EN
    logic [DIG-1:0] w_blank;
    logic [DIG-1:0] r_blank;

    // Walk down from the top digit; a digit blanks only while every digit
    // above it is also zero. The ones digit always shows.
    always_comb begin
        logic v_zero;
        w_blank = '0;
        v_zero  = 1'b1;
        for (int i = DIG - 1; i >= 1; i--) begin
            v_zero     = v_zero && (w_new_bcd[4*i +: 4] == 4'd0);
            w_blank[i] = v_zero;
        end
    end

    assign bus.blank = r_blank;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_scratch <= '0;
            r_bcd     <= '0;
`ifdef BCD_LZB_EN
            r_blank   <= '0;
`endif
        end else if (w_load) begin
            r_cnt     <= '0;
            r_scratch <= {{(4*DIG){1'b0}}, bus.bin_in};
        end else if (w_step) begin
            r_cnt     <= r_cnt + 1'b1;
            r_scratch <= w_shifted;
            if (w_last) begin
                r_bcd   <= w_new_bcd;
`ifdef BCD_LZB_EN
                r_blank <= w_blank;
`endif
            end
        end
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = (r_state == DONE);
    assign bus.bcd_out = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.BIN_W(8), .DIG(3)) bus ();

    bin2bcd_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic [2:0]  blank;
    } vec_t;

    vec_t        sb_q[$];
    vec_t        tbl[9];
    int          total    = 0;
    int          bad      = 0;
    int          done_cnt = 0;
    int          cyc      = 0;
    logic [11:0] last_bcd = '0;
    logic        prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        vec_t e;
        if (reset) begin
            if (bus.done) begin
                done_cnt++;
                check("done_one_cycle", {31'b0, prev_done}, 32'd0);
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done actual=done expected=no pending conversion");
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("bcd_out(%0d)", e.bin), {20'b0, bus.bcd_out}, {20'b0, e.bcd});
`ifdef BCD_LZB_EN
                    check($sformatf("blank(%0d)", e.bin), {29'b0, bus.blank}, {29'b0, e.blank});
`endif
                    last_bcd = e.bcd;
                end
            end
            prev_done = bus.done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic push_exp(input logic [7:0] v, input logic [11:0] b, input logic [2:0] bl);
        vec_t e;
        e.bin   = v;
        e.bcd   = b;
        e.blank = bl;
        sb_q.push_back(e);
    endtask

    task automatic convert(input logic [7:0] v, input logic [11:0] e_bcd, input logic [2:0] e_blank);
        int   k;
        int   d0;
        logic hold_ok;
        @(negedge clk);
        push_exp(v, e_bcd, e_blank);
        bus.start  = 1'b1;
        bus.bin_in = v;
        d0 = done_cnt;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bin_in = ~v;
        check("busy_after_start", {31'b0, bus.busy}, 32'd1);
        k = 0;
        hold_ok = 1'b1;
        while (!bus.done && k < 20) begin
            @(negedge clk);
            k++;
            if (!bus.done && bus.bcd_out !== last_bcd) hold_ok = 1'b0;
        end
        check($sformatf("latency(%0d)", v), k, 32'd8);
        check("bcd_hold_in_shift", {31'b0, hold_ok}, 32'd1);
        @(negedge clk);
        check("busy_after_done", {31'b0, bus.busy}, 32'd0);
        check("done_after_done", {31'b0, bus.done}, 32'd0);
        check("done_pulses", done_cnt - d0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int d0;
        int got;
        int times[3];

        tbl[0] = '{8'd0,   12'h000, 3'b110};
        tbl[1] = '{8'd9,   12'h009, 3'b110};
        tbl[2] = '{8'd99,  12'h099, 3'b100};
        tbl[3] = '{8'd255, 12'h255, 3'b000};
        tbl[4] = '{8'd7,   12'h007, 3'b110};
        tbl[5] = '{8'd45,  12'h045, 3'b100};
        tbl[6] = '{8'd100, 12'h100, 3'b000};
        tbl[7] = '{8'd10,  12'h010, 3'b100};
        tbl[8] = '{8'd199, 12'h199, 3'b000};

        bus.start  = 1'b0;
        bus.bin_in = '0;
        reset      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_bcd",  {20'b0, bus.bcd_out}, 32'd0);
`ifdef BCD_LZB_EN
        check("rst_blank", {29'b0, bus.blank}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        convert(8'd225, 12'h225, 3'b000);

        for (int i = 0; i < 9; i++) convert(tbl[i].bin, tbl[i].bcd, tbl[i].blank);

        // Start pulses during SHIFT and during DONE must be ignored.
        @(negedge clk);
        push_exp(8'd150, 12'h150, 3'b000);
        bus.start  = 1'b1;
        bus.bin_in = 8'd150;
        d0 = done_cnt;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bin_in = 8'd37;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 3;
        while (!bus.done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ign_latency", k, 32'd8);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("ign_done_low", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        check("ign_busy_low", {31'b0, bus.busy}, 32'd0);
        check("ign_done_pulses", done_cnt - d0, 32'd1);

        // Reset in the middle of a conversion aborts it.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 8'd200;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        check("abort_bcd",  {20'b0, bus.bcd_out}, 32'd0);
`ifdef BCD_LZB_EN
        check("abort_blank", {29'b0, bus.blank}, 32'd0);
`endif
        last_bcd = 12'h000;
        @(negedge clk);
        reset = 1'b1;
        convert(8'd45, 12'h045, 3'b100);

        // Start held high: back-to-back conversions every 10 cycles.
        @(negedge clk);
        for (int i = 0; i < 3; i++) push_exp(8'd128, 12'h128, 3'b000);
        bus.start  = 1'b1;
        bus.bin_in = 8'd128;
        got = 0;
        k = 0;
        times[0] = 0;
        times[1] = 0;
        times[2] = 0;
        while (got < 3 && k < 60) begin
            @(negedge clk);
            k++;
            if (bus.done) begin
                times[got] = cyc;
                got++;
            end
        end
        bus.start = 1'b0;
        check("held_count", got, 32'd3);
        check("held_gap1", times[1] - times[0], 32'd10);
        check("held_gap2", times[2] - times[1], 32'd10);
        repeat (3) @(negedge clk);
        check("held_idle", {31'b0, bus.busy}, 32'd0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
